// File: rtl/tqvp_vga_capture.sv
// TinyQV video-capture peripheral: sync timing, single-pixel probe and per-frame checksum.
// Define TQVP_VGA_CAP_CRC_EN to replace the 24-bit additive checksum with CRC-16/CCITT.
module tqvp_vga_capture #(
    parameter bit          POLARITY = 1'b1,
    parameter int unsigned CNT_W    = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int unsigned CHK_W = 24;
    localparam int unsigned PIX_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [5:0] A_CTRL      = 6'h00;
    localparam logic [5:0] A_CAP_XY    = 6'h04;
    localparam logic [5:0] A_STATUS    = 6'h08;
    localparam logic [5:0] A_TIMING    = 6'h0C;
    localparam logic [5:0] A_CHECKSUM  = 6'h10;
    localparam logic [5:0] A_FRAME_CNT = 6'h14;

`ifdef TQVP_VGA_CAP_CRC_EN
    localparam logic [CHK_W-1:0] CHK_INIT = 24'h00FFFF;

    // Byte-wide CRC-16/CCITT step, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction
`else
    localparam logic [CHK_W-1:0] CHK_INIT = '0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VSYNC, ST_CAPTURE, ST_DONE} state_e;

    state_e           state_q, state_d;
    logic [7:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [CNT_W-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             irq_en_q, irq_en_d, done_q, done_d, sval_q, sval_d, irq_q, irq_d;
    logic [PIX_W-1:0] sample_q, sample_d;
    logic [CHK_W-1:0] chk_q, chk_d;

    logic             hs_edge, vs_edge, busy, arm, accumulate;
    logic [31:0]      wmask, capxy_rd, capxy_wr;
    logic             unused_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // s2 only needs the sync bits for edge detection.
    assign hs_edge = (s1_q[6] == POLARITY) && (s2_q[0] != POLARITY);
    assign vs_edge = (s1_q[7] == POLARITY) && (s2_q[1] != POLARITY);
    assign busy    = (state_q == ST_WAIT_VSYNC) || (state_q == ST_CAPTURE);
    assign arm     = (address == A_CTRL) && wmask[0] && data_in[0];

    assign uo_out         = s1_q;
    assign user_interrupt = irq_q;
    assign data_ready     = 1'b1;
    assign unused_ok      = ^{data_read_n, capxy_wr};

    always_comb begin : wr_lanes
        case (data_write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            2'b10:   wmask = 32'hFFFF_FFFF;
            default: wmask = 32'h0000_0000;
        endcase
    end

    always_comb begin : capxy_view
        capxy_rd               = '0;
        capxy_rd[CNT_W-1:0]    = cap_x_q;
        capxy_rd[16 +: CNT_W]  = cap_y_q;
        capxy_wr               = (capxy_rd & ~wmask) | (data_in & wmask);
    end

    always_comb begin : next_state
        state_d       = state_q;
        s1_d          = ui_in;
        s2_d          = s1_q[7:6];
        x_cnt_d       = hs_edge ? '0 : sat_inc(x_cnt_q);
        y_cnt_d       = y_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        frame_cnt_d   = frame_cnt_q;
        cap_x_d       = cap_x_q;
        cap_y_d       = cap_y_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        sval_d        = sval_q;
        sample_d      = sample_q;
        chk_d         = chk_q;
        accumulate    = 1'b0;

        if (vs_edge) begin
            y_cnt_d       = '0;
            frame_lines_d = sat_inc(y_cnt_q);
            frame_cnt_d   = frame_cnt_q + 16'd1;
        end else if (hs_edge) begin
            y_cnt_d = sat_inc(y_cnt_q);
        end
        if (hs_edge) line_len_d = sat_inc(x_cnt_q);

        if ((address == A_CTRL) && wmask[1]) irq_en_d = data_in[1];
        if (address == A_CAP_XY) begin
            cap_x_d = capxy_wr[CNT_W-1:0];
            cap_y_d = capxy_wr[16 +: CNT_W];
        end
        if ((address == A_STATUS) && wmask[0] && data_in[0]) done_d = 1'b0;

        // The FSM runs after the W1C so a DONE set in the same cycle wins.
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d  = ST_WAIT_VSYNC;
                    done_d   = 1'b0;
                    sval_d   = 1'b0;
                    sample_d = '0;
                    chk_d    = CHK_INIT;
                end
            end
            ST_WAIT_VSYNC: begin
                if (vs_edge) begin
                    state_d    = ST_CAPTURE;
                    accumulate = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (vs_edge) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    accumulate = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accumulate) begin
`ifdef TQVP_VGA_CAP_CRC_EN
            chk_d = {8'h00, crc16_step(chk_q[15:0], {2'b00, s1_q[5:0]})};
`else
            chk_d = chk_q + CHK_W'(s1_q[5:0]);
`endif
            if (!sval_q && (x_cnt_d == cap_x_q) && (y_cnt_d == cap_y_q)) begin
                sval_d   = 1'b1;
                sample_d = s1_q[5:0];
            end
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            s1_q          <= '0;
            s2_q          <= '0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_cnt_q   <= '0;
            cap_x_q       <= '0;
            cap_y_q       <= '0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            sval_q        <= 1'b0;
            sample_q      <= '0;
            chk_q         <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_cnt_q   <= frame_cnt_d;
            cap_x_q       <= cap_x_d;
            cap_y_q       <= cap_y_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            sval_q        <= sval_d;
            sample_q      <= sample_d;
            chk_q         <= chk_d;
            irq_q         <= irq_d;
        end
    end

    always_comb begin : rd_mux
        data_out = '0;
        case (address)
            A_CTRL:      data_out = {30'h0, irq_en_q, 1'b0};
            A_CAP_XY:    data_out = capxy_rd;
            A_STATUS:    data_out = {18'h0, sample_q, 5'h0, sval_q, busy, done_q};
            A_TIMING: begin
                data_out[CNT_W-1:0]   = line_len_q;
                data_out[16 +: CNT_W] = frame_lines_q;
            end
            A_CHECKSUM:  data_out = {8'h0, chk_q};
            A_FRAME_CNT: data_out = {16'h0, frame_cnt_q};
            default:     data_out = '0;
        endcase
    end
endmodule
